// File: rtl/led_result_pacer.sv
// led_result_pacer: queues result words from an upstream stage in a small
// circular FIFO and shows each one on the board LEDs for a fixed number of
// clock cycles, so that fast bursts of results stay readable by a human.
module led_result_pacer #(
    parameter int HOLD_CYCLES = 4,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] led,
    output logic       busy,
    output logic [7:0] shown_count
);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] FULL_LVL  = 3'(DEPTH);

    state_t     state;
    state_t     state_next;
    logic [7:0] mem [DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic [3:0] hold_cnt;
    logic       push;
    logic       pop;
    logic       hold_dec;

    // Readiness depends only on the stored occupancy, so upstream never sees
    // a combinational path from its own valid back to ready.
    assign in_ready = (count != FULL_LVL);
    assign push     = in_valid & in_ready;
    assign busy     = (state == SHOW);

    // Storage array; the data itself needs no reset because occupancy gates it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                count <= count + 3'd1;
            end else if (pop && !push) begin
                count <= count - 3'd1;
            end
        end
    end

    // Display state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and pop decision use pre-edge occupancy, so a word pushed at
    // one edge can only reach the LEDs at the following edge.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        hold_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    pop        = 1'b1;
                    state_next = SHOW;
                end
            end
            SHOW: begin
                if (hold_cnt != 4'd0) begin
                    hold_dec = 1'b1;
                end else if (count != 3'd0) begin
                    pop = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // LED register, hold timer and shown counter; led keeps its last word when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led         <= 8'h00;
            hold_cnt    <= 4'd0;
            shown_count <= 8'd0;
        end else if (pop) begin
            led         <= mem[rd_ptr];
            hold_cnt    <= HOLD_LOAD;
            shown_count <= shown_count + 8'd1;
        end else if (hold_dec) begin
            hold_cnt <= hold_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_led_result_pacer.sv
// Testbench for led_result_pacer: two instances (hold of 4 and hold of 1)
// driven one at a time and compared each cycle against a timestamp-based
// reference model of the pacing rules.
module tb_led_result_pacer;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       in_valid4;
    logic       in_valid1;
    logic [7:0] in_data;
    logic       in_ready4;
    logic       in_ready1;
    logic [7:0] led4;
    logic [7:0] led1;
    logic       busy4;
    logic       busy1;
    logic [7:0] shown4;
    logic [7:0] shown1;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] mq[$];
    int         edge_no;
    int         last_load;
    bit         loaded;
    logic [7:0] m_led;
    logic [7:0] m_shown;
    int         hold_m;
    bit         m_acc;

    led_result_pacer #(.HOLD_CYCLES(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data),
        .in_ready(in_ready4), .led(led4), .busy(busy4), .shown_count(shown4)
    );

    led_result_pacer #(.HOLD_CYCLES(1), .DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data),
        .in_ready(in_ready1), .led(led1), .busy(busy1), .shown_count(shown1)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] obsLed();
        return sel ? led1 : led4;
    endfunction

    function automatic logic obsBusy();
        return sel ? busy1 : busy4;
    endfunction

    function automatic logic [7:0] obsShown();
        return sel ? shown1 : shown4;
    endfunction

    function automatic logic obsReady();
        return sel ? in_ready1 : in_ready4;
    endfunction

    function automatic logic modelBusy();
        return loaded && ((edge_no - last_load) < hold_m);
    endfunction

    function automatic logic modelReady();
        return mq.size() < 4;
    endfunction

    task automatic modelReset();
        mq.delete();
        loaded  = 1'b0;
        m_led   = 8'h00;
        m_shown = 8'd0;
        m_acc   = 1'b0;
    endtask

    // One rising edge: a word is loaded when something was queued before
    // the edge and the previous word has had its full hold time.
    task automatic modelEdge(input logic v, input logic [7:0] d);
        int pre;
        edge_no++;
        pre   = mq.size();
        m_acc = v && (pre < 4);
        if (pre > 0 && (!loaded || (edge_no - last_load) >= hold_m)) begin
            m_led     = mq.pop_front();
            last_load = edge_no;
            loaded    = 1'b1;
            m_shown   = m_shown + 8'd1;
        end
        if (m_acc) begin
            mq.push_back(d);
        end
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, "_led"},   obsLed(),          m_led);
        cmp({tag, "_busy"},  8'(obsBusy()),     8'(modelBusy()));
        cmp({tag, "_shown"}, obsShown(),        m_shown);
        cmp({tag, "_ready"}, 8'(obsReady()),    8'(modelReady()));
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input string tag);
        in_valid4 = sel ? 1'b0 : v;
        in_valid1 = sel ? v : 1'b0;
        in_data   = d;
        @(posedge clk);
        modelEdge(v, d);
        #1;
        checkOutput(tag);
    endtask

    // reset pulse placed between edges; checked while asserted
    task automatic pulseReset(input string tag);
        in_valid4 = 1'b0;
        in_valid1 = 1'b0;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        cmp({tag, "_rst_led"},   obsLed(),         8'h00);
        cmp({tag, "_rst_ready"}, 8'(obsReady()),   8'h01);
        cmp({tag, "_rst_shown"}, obsShown(),       8'h00);
        cmp({tag, "_rst_busy"},  8'(obsBusy()),    8'h00);
        #2;
        rst_n = 1'b1;
    endtask

    // streams words[] with valid held until each is accepted, within a cycle budget
    task automatic sendStream(input logic [7:0] words[$], input int budget, input string tag);
        int k;
        int cyc;
        bit saw_low;
        k       = 0;
        cyc     = 0;
        saw_low = 1'b0;
        while (k < words.size() && cyc < budget) begin
            applyStimulus(1'b1, words[k], tag);
            if (m_acc) k++;
            if (!obsReady()) saw_low = 1'b1;
            cyc++;
        end
        cmp({tag, "_done"}, 8'(k == words.size()), 8'h01);
        in_valid4 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    initial begin
        logic [7:0] words[$];
        logic [7:0] pend_data;
        bit         pending;

        rst_n     = 1'b0;
        sel       = 1'b0;
        in_valid4 = 1'b0;
        in_valid1 = 1'b0;
        in_data   = 8'h00;
        hold_m    = 4;
        edge_no   = 0;
        last_load = 0;
        modelReset();

        #2;
        checkOutput("reset");
        #10;
        rst_n = 1'b1;
        #1;
        checkOutput("release");

        // single word A5
        applyStimulus(1'b1, 8'hA5, "single");
        applyStimulus(1'b0, 8'h00, "single");
        cmp("single_led_e2", obsLed(), 8'hA5);
        cmp("single_busy_e2", 8'(obsBusy()), 8'h01);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, "single");
        cmp("single_idle_busy", 8'(obsBusy()), 8'h00);
        cmp("single_idle_led", obsLed(), 8'hA5);
        cmp("single_idle_shown", obsShown(), 8'h01);

        // burst 01..04 on consecutive edges
        words = {8'h01, 8'h02, 8'h03, 8'h04};
        sendStream(words, 20, "burst");
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, "burst_drain");
        cmp("burst_shown", obsShown(), 8'h05);

        // overflow backpressure 10..17
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back(8'(8'h10 + i));
        sendStream(words, 100, "ovf");
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'h00, "ovf_drain");
        cmp("ovf_last_led", obsLed(), 8'h17);

        // long random stream keeps FIFO near full and wraps pointers
        words.delete();
        for (int i = 0; i < 12; i++) words.push_back(8'($urandom));
        sendStream(words, 150, "wrap");
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'h00, "wrap_drain");

        // random valid/data with upstream holding unaccepted words
        pending   = 1'b0;
        pend_data = 8'h00;
        for (int i = 0; i < 200; i++) begin
            if (!pending && ($urandom_range(0, 2) != 0)) begin
                pending   = 1'b1;
                pend_data = 8'($urandom);
            end
            applyStimulus(pending, pend_data, "rand");
            if (m_acc) pending = 1'b0;
        end
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'h00, "rand_drain");

        // reset mid-SHOW with three words queued
        applyStimulus(1'b1, 8'h21, "rms");
        applyStimulus(1'b1, 8'h22, "rms");
        applyStimulus(1'b1, 8'h23, "rms");
        applyStimulus(1'b0, 8'h00, "rms");
        pulseReset("rms");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, "rms_quiet");
        cmp("rms_quiet_led", obsLed(), 8'h00);
        applyStimulus(1'b1, 8'h3C, "rms_push");
        applyStimulus(1'b0, 8'h00, "rms_show");
        cmp("rms_led_3c", obsLed(), 8'h3C);
        cmp("rms_shown_1", obsShown(), 8'h01);

        // switch to the hold-of-1 instance
        pulseReset("sw");
        sel    = 1'b1;
        hold_m = 1;
        #1;
        checkOutput("h1_reset");
        words.delete();
        for (int i = 0; i < 300; i++) words.push_back(8'(8'h80 + i));
        sendStream(words, 400, "h1");
        applyStimulus(1'b0, 8'h00, "h1_drain");
        applyStimulus(1'b0, 8'h00, "h1_drain");
        cmp("h1_wrap_shown", obsShown(), 8'(300));
        cmp("h1_last_led", obsLed(), 8'(8'h80 + 299));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
